imem_loader: RTL
================

IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 SHALL have parameter ADDR_W, default 8, instruction-memory word-address width.
REQ-002 SHALL have parameter MAX_WORDS, default 256, largest accepted program length in words.
REQ-003 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port start  input  1  one-cycle pulse that opens a load session.
REQ-006 SHALL have port byte_in  input  8  program byte stream.
REQ-007 SHALL have port byte_valid  input  1  byte_in holds a valid byte.
REQ-008 SHALL have port byte_ready  output  1  loader accepts byte this cycle.
REQ-009 SHALL have port imem_we  output  1  instruction-memory write strobe.
REQ-010 SHALL have port imem_waddr  output  ADDR_W  word address of the write.
REQ-011 SHALL have port imem_wdata  output  32  instruction word written.
REQ-012 SHALL have port cpu_reset  output  1  active-high hold-in-reset for the processor.
REQ-013 SHALL have ports busy, done, error  output  1 each  session status.
REQ-014 SHALL have port word_count  output  16  words written in the current or last session.

Function
REQ-015 SHALL implement states IDLE, LEN_HI, LEN_LO, DATA, WRITE, DONE, ERR.
REQ-016 Byte transfer SHALL occur only on a cycle with byte_valid=1 and byte_ready=1.
REQ-017 byte_ready SHALL be 1 only in LEN_HI, LEN_LO and DATA.
REQ-018 IDLE->LEN_HI on start; start SHALL be ignored in LEN_HI, LEN_LO, DATA and WRITE.
REQ-019 LEN_HI and LEN_LO SHALL capture the 16-bit big-endian length N, high byte first.
REQ-020 After LEN_LO: N=0 -> DONE; N>MAX_WORDS -> ERR; otherwise -> DATA.
REQ-021 DATA SHALL pack 4 bytes big-endian: first byte into wdata[31:24], last byte into [7:0]; a 2-bit lane counter wraps 3->0.
REQ-022 The 4th byte transfer SHALL move to WRITE; imem_we SHALL be 1 for exactly that one cycle, the cycle after the handshake.
REQ-023 imem_waddr SHALL equal the word index (0, 1, ... N-1), truncated to ADDR_W bits.
REQ-024 word_count SHALL increment in the WRITE cycle.
REQ-025 WRITE->DONE when word_count reaches N, else WRITE->DATA.
REQ-026 byte_valid gaps SHALL stall the FSM with no state or data change and no timeout.
REQ-027 busy SHALL be 1 in LEN_HI, LEN_LO, DATA and WRITE; done SHALL be 1 only in DONE; error SHALL be 1 only in ERR.
REQ-028 cpu_reset SHALL be 0 only in DONE.
REQ-029 start in DONE or ERR SHALL clear word_count, the lane counter and error, and enter LEN_HI.
REQ-030 All outputs SHALL be registered or decoded from registered state only.

Reset
REQ-031 On reset low: state=IDLE, imem_we=0, imem_waddr=0, imem_wdata=0, word_count=0, busy=0, done=0, error=0, byte_ready=0, cpu_reset=1.
REQ-032 Reset mid-session SHALL discard any partial word; words already written SHALL not be undone.

Structure
REQ-033 Package imem_loader_pkg SHALL hold the state enum, BYTES_PER_WORD=4, LEN_BYTES=2 and the MAX_WORDS default.
REQ-034 Byte-to-word assembly SHALL be sub-module byte_packer (lane counter, shift register, word_full flag).

Verification
REQ-035 Reset, no start for 20 cycles -> cpu_reset=1, byte_ready=0, imem_we=0.
REQ-036 start; bytes 00 02 20 08 00 05 AC 08 00 00 -> writes [0]=0x20080005 and [1]=0xAC080000, then done=1, cpu_reset=0, word_count=2.
REQ-037 start; bytes 00 00 -> DONE with no imem_we pulse and word_count=0.
REQ-038 MAX_WORDS=256; length bytes 01 01 -> error=1, byte_ready=0, no imem_we, cpu_reset=1.
REQ-039 Stream from REQ-036 with byte_valid toggling every cycle -> identical writes and addresses, one imem_we per word.
REQ-040 Reset after 2 data bytes, then rerun REQ-036 -> first write [0]=0x20080005; no stale bytes.

Source files
------------

// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory loader.
//   loaderState_t     : loader FSM states
//   BYTES_PER_WORD    : bytes packed into one instruction word
//   LEN_BYTES         : bytes in the big-endian length header
//   MAX_WORDS_DEFAULT : default upper bound on program length in words
package imem_loader_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LEN_HI = 3'd1,
        LEN_LO = 3'd2,
        DATA   = 3'd3,
        WRITE  = 3'd4,
        DONE   = 3'd5,
        ERR    = 3'd6
    } loaderState_t;

    localparam int unsigned BYTES_PER_WORD    = 4;
    localparam int unsigned LEN_BYTES         = 2;
    localparam int unsigned MAX_WORDS_DEFAULT = 256;

endpackage

// File: rtl/byte_packer.sv
// Assembles a byte stream into 32-bit big-endian words.
//   clk, reset : clock, asynchronous active-low reset
//   clear      : drop any partial word and restart at lane 0
//   load       : accept byteIn this cycle
//   byteIn     : incoming byte
//   word       : shift register; first byte of a word ends up in [31:24]
//   lastLane   : the next load completes a word
//   wordFull   : word holds a complete word (until the next load or clear)
module byte_packer
    import imem_loader_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,
    input  logic        load,
    input  logic [7:0]  byteIn,
    output logic [31:0] word,
    output logic        lastLane,
    output logic        wordFull
);

    localparam int unsigned LaneW = $clog2(BYTES_PER_WORD);

    logic [LaneW-1:0] laneQ;

    assign lastLane = (laneQ == LaneW'(BYTES_PER_WORD - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            laneQ    <= '0;
            word     <= '0;
            wordFull <= 1'b0;
        end else if (clear) begin
            laneQ    <= '0;
            wordFull <= 1'b0;
        end else if (load) begin
            // Shifting left leaves the earliest byte in the top lane.
            word     <= {word[23:0], byteIn};
            laneQ    <= laneQ + 1'b1;
            wordFull <= lastLane;
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Loads a length-prefixed byte stream into instruction memory and holds
// the processor in reset until the program is complete.
//   clk, reset            : clock, asynchronous active-low reset
//   start                 : opens a load session (IDLE, DONE or ERR only)
//   byte_in/valid/ready   : byte stream handshake
//   imem_we/waddr/wdata   : one-cycle instruction-memory write
//   cpu_reset             : high except once a load has completed
//   busy, done, error     : session status
//   word_count            : words written in the current or last session
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int unsigned ADDR_W    = 8,
    parameter int unsigned MAX_WORDS = MAX_WORDS_DEFAULT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [7:0]        byte_in,
    input  logic              byte_valid,
    output logic              byte_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_waddr,
    output logic [31:0]       imem_wdata,
    output logic              cpu_reset,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [15:0]       word_count
);

    localparam int unsigned LenW = 8 * LEN_BYTES;

    loaderState_t     stateQ, stateD;
    logic [LenW-1:0]  lenQ, lenD;
    logic [15:0]      wordCountQ, wordCountD;
    logic [LenW-1:0]  lenFull;
    logic             xfer;
    logic             startAccepted;
    logic             lastLane;
    logic             wordFull;
    logic [31:0]      packedWord;

    assign xfer          = byte_valid && byte_ready;
    assign startAccepted = start && (stateQ inside {IDLE, DONE, ERR});
    assign lenFull       = {lenQ[15:8], byte_in};

    byte_packer u_packer (
        .clk      (clk),
        .reset    (reset),
        .clear    (startAccepted),
        .load     (xfer && (stateQ == DATA)),
        .byteIn   (byte_in),
        .word     (packedWord),
        .lastLane (lastLane),
        .wordFull (wordFull)
    );

    always_comb begin
        stateD     = stateQ;
        lenD       = lenQ;
        wordCountD = wordCountQ;
        unique case (stateQ)
            IDLE, DONE, ERR: begin
                if (start) begin
                    stateD     = LEN_HI;
                    wordCountD = '0;
                end
            end
            LEN_HI: begin
                if (xfer) begin
                    lenD[15:8] = byte_in;
                    stateD     = LEN_LO;
                end
            end
            LEN_LO: begin
                if (xfer) begin
                    lenD[7:0] = byte_in;
                    if (lenFull == '0) begin
                        stateD = DONE;
                    end else if ({16'b0, lenFull} > MAX_WORDS) begin
                        stateD = ERR;
                    end else begin
                        stateD = DATA;
                    end
                end
            end
            DATA: begin
                if (xfer && lastLane) begin
                    stateD = WRITE;
                end
            end
            WRITE: begin
                wordCountD = wordCountQ + 16'd1;
                stateD     = (wordCountD == lenQ) ? DONE : DATA;
            end
            default: stateD = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stateQ     <= IDLE;
            lenQ       <= '0;
            wordCountQ <= '0;
        end else begin
            stateQ     <= stateD;
            lenQ       <= lenD;
            wordCountQ <= wordCountD;
        end
    end

    // Everything below decodes registered state only.
    assign byte_ready = stateQ inside {LEN_HI, LEN_LO, DATA};
    assign busy       = stateQ inside {LEN_HI, LEN_LO, DATA, WRITE};
    assign done       = (stateQ == DONE);
    assign error      = (stateQ == ERR);
    assign cpu_reset  = (stateQ != DONE);
    assign imem_we    = (stateQ == WRITE) && wordFull;
    assign imem_waddr = wordCountQ[ADDR_W-1:0];
    assign imem_wdata = packedWord;
    assign word_count = wordCountQ;

endmodule
